// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: shifts by at most STEP positions per BUSY cycle.
// Define SEQ_SHIFTER_ROTATE_EN to add ROL/ROR; otherwise those codes are unsupported.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP_N = SHW'(STEP);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0010;
  localparam logic [3:0] OP_SRA = 4'b0011;
  localparam logic [3:0] OP_ROL = 4'b0100;
  localparam logic [3:0] OP_ROR = 4'b0101;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   remaining;
  logic [3:0]       op_q;
  logic [SHW-1:0]   n;
  logic [SHW-1:0]   rem_nxt;
  logic [SHW-1:0]   sh;
  logic             unused_b;

  assign unused_b = ^b[WIDTH-1:SHW];
  assign sh       = b[SHW-1:0];

  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:         ok = 1'b1;
`endif
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Rotations use -amt (mod WIDTH) for the wrap-around part; amt is never 0 in BUSY.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] val,
                                                  input logic [3:0]       op,
                                                  input logic [SHW-1:0]   amt);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   inv;
    inv = -amt;
    case (op)
      OP_SLL:  r = val << amt;
      OP_SRL:  r = val >> amt;
      OP_SRA:  r = $unsigned($signed(val) >>> amt);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL:  r = (val << amt) | (val >> inv);
      OP_ROR:  r = (val >> amt) | (val << inv);
`endif
      default: r = '0;
    endcase
    if (inv == '0) r = r;
    return r;
  endfunction

  always_comb begin
    n       = (remaining < STEP_N) ? remaining : STEP_N;
    rem_nxt = remaining - n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= operation;
            if (op_supported(operation)) begin
              acc       <= a;
              remaining <= sh;
              state     <= (sh == '0) ? DONE : BUSY;
            end else begin
              acc       <= '0;
              remaining <= '0;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc       <= shift_step(acc, op_q, n);
          remaining <= rem_nxt;
          if (rem_nxt == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;
  assign zero_flag = (acc == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Table-driven bench for seq_shifter (WIDTH=32, STEP=4) with a result scoreboard queue.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;

  seq_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation(operation), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one request, scrambles inputs while busy, checks latency and result.
  task automatic run_req(input string name, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp, input int lat);
    int          cyc;
    logic [31:0] want;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({name, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; a = av; b = bv; operation = op;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    a = $urandom; b = $urandom; operation = 4'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      a = $urandom; b = $urandom;
    end
    in_valid = 1'b0;
    check({name, " latency"}, cyc, lat);
    want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check({name, " result"}, result, want);
    check({name, " zero_flag"}, zero_flag, (want == 32'h0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " back to idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    vecs[0]  = '{4'h1, 32'h0000_0001, 32'd5,  32'h0000_0020, 2};
    vecs[1]  = '{4'h3, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 8};
    vecs[2]  = '{4'h2, 32'h8000_0000, 32'd31, 32'h0000_0001, 8};
    vecs[3]  = '{4'h1, 32'h0000_0001, 32'd36, 32'h0000_0010, 1};
    vecs[4]  = '{4'h1, 32'h1234_5678, 32'd0,  32'h1234_5678, 0};
    vecs[5]  = '{4'hF, 32'h0000_04D2, 32'd3,  32'h0000_0000, 0};
    vecs[6]  = '{4'h3, 32'h7FFF_FFF0, 32'd6,  32'h01FF_FFFF, 2};
    vecs[7]  = '{4'h2, 32'hF000_0000, 32'd13, 32'h0007_8000, 4};
    vecs[8]  = '{4'h1, 32'hFFFF_FFFF, 32'd32, 32'hFFFF_FFFF, 0};
    vecs[9]  = '{4'h0, 32'h0000_0005, 32'd0,  32'h0000_0000, 0};
    vecs[10] = '{4'h1, 32'h8000_0000, 32'd1,  32'h0000_0000, 1};
`ifdef SEQ_SHIFTER_ROTATE_EN
    vecs[11] = '{4'h5, 32'h0000_0001, 32'd1,  32'h8000_0000, 1};
    vecs[12] = '{4'h4, 32'h8000_0001, 32'd4,  32'h0000_0018, 1};
    vecs[13] = '{4'h5, 32'h1234_5678, 32'd8,  32'h7812_3456, 2};
`else
    vecs[11] = '{4'h5, 32'h0000_0001, 32'd1,  32'h0000_0000, 0};
    vecs[12] = '{4'h4, 32'h8000_0001, 32'd4,  32'h0000_0000, 0};
    vecs[13] = '{4'h5, 32'h1234_5678, 32'd8,  32'h0000_0000, 0};
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; operation = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {in_ready, out_valid, zero_flag, result}, {3'b101, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset outputs", {in_ready, out_valid, zero_flag, result}, {3'b101, 32'h0});

    for (int i = 0; i < 14; i++)
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // DONE held with out_ready low while a competing request waits.
    in_valid = 1'b1; a = 32'h3; b = 32'd2; operation = 4'h1;
    @(posedge clk);
    sb.push_back(32'hC);
    #1;
    @(posedge clk); #1;
    check("stall enter done", out_valid, 1);
    held = result;
    a = 32'hAAAA_5555; b = 32'd0; operation = 4'h2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall hold %0d", i), {out_valid, in_ready, result}, {2'b10, held});
    end
    check("stall result", held, sb.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release no accept", {in_ready, out_valid}, 2'b10);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a long shift.
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd20; operation = 4'h2;
    @(posedge clk);
    sb.push_back(32'h0000_0FFF);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("busy before reset", {in_ready, out_valid}, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset", {in_ready, out_valid, zero_flag, result}, {3'b101, 32'h0});
    sb.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset idle", {in_ready, out_valid, zero_flag, result}, {3'b101, 32'h0});
    run_req("after reset", 4'h2, 32'hFFFF_FFFF, 32'd20, 32'h0000_0FFF, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
